// File: rtl/b04_sample_feeder.sv
// Upstream feeder for the b04 max/min/average processor: buffers samples in a small FIFO,
// covers the processor start-up with two WARM cycles, and cuts the stream into restart-delimited frames.
module b04_sample_feeder #(
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int FRAME_LEN = 8
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [7:0]    IN_DATA,
    input  logic          MODE_AVG,
    output logic [7:0]    DATA_IN,
    output logic          ENABLE,
    output logic          RESTART,
    output logic          AVERAGE,
    output logic          FRAME_DONE,
    output logic [AW:0]   LEVEL
);

    localparam int          DATA_W     = 8;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAME_LEN);

    typedef enum logic [1:0] {WARM0, WARM1, STREAM, GAP} state_t;

    state_t                     state, state_nx;
    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic signed [DATA_W-1:0]   head_p0;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [7:0]                 cnt, cnt_nx, cnt_inc;
    logic [DATA_W-1:0]          data_nx;
    logic                       enable_nx, restart_nx, average_nx, done_nx;
    logic                       push, pop;

    // Full FIFO refuses a push even when the same cycle pops: no bypass path.
    assign IN_READY = (LEVEL != FULL_LEVEL);
    assign push     = IN_VALID && IN_READY;
    assign head_p0  = mem[rd_ptr];
    assign cnt_inc  = cnt + 8'd1;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        data_nx    = DATA_IN;
        enable_nx  = 1'b0;
        restart_nx = 1'b0;
        done_nx    = 1'b0;
        average_nx = AVERAGE;
        pop        = 1'b0;
        case (state)
            WARM0: state_nx = WARM1;
            WARM1: begin
                state_nx   = STREAM;
                average_nx = MODE_AVG;
            end
            STREAM: begin
                if (LEVEL != '0) begin
                    pop       = 1'b1;
                    data_nx   = head_p0;
                    enable_nx = 1'b1;
                    cnt_nx    = cnt_inc;
                    if (cnt_inc == FRAME_LAST) state_nx = GAP;
                end
            end
            GAP: begin
                restart_nx = 1'b1;
                done_nx    = 1'b1;
                cnt_nx     = 8'd0;
                average_nx = MODE_AVG;
                state_nx   = STREAM;
            end
            default: state_nx = WARM0;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge CLOCK) begin
        if (push) mem[wr_ptr] <= IN_DATA;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= WARM0;
            cnt        <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            LEVEL      <= '0;
            DATA_IN    <= '0;
            ENABLE     <= 1'b0;
            RESTART    <= 1'b0;
            AVERAGE    <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            DATA_IN    <= data_nx;
            ENABLE     <= enable_nx;
            RESTART    <= restart_nx;
            AVERAGE    <= average_nx;
            FRAME_DONE <= done_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

endmodule

// File: tb/tb_b04_sample_feeder.sv
// Scoreboard bench for b04_sample_feeder: the driver queues accepted samples, the monitor
// checks the processor-side stream against a frame/occupancy model every cycle.
module tb_b04_sample_feeder;

    localparam int DEPTH     = 4;
    localparam int AW        = 2;
    localparam int FRAME_LEN = 8;

    logic          CLOCK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          IN_VALID = 1'b0;
    logic [7:0]    IN_DATA = 8'h00;
    logic          MODE_AVG = 1'b0;
    logic          IN_READY;
    logic [7:0]    DATA_IN;
    logic          ENABLE, RESTART, AVERAGE, FRAME_DONE;
    logic [AW:0]   LEVEL;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    b04_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FRAME_LEN)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .MODE_AVG(MODE_AVG), .DATA_IN(DATA_IN), .ENABLE(ENABLE),
        .RESTART(RESTART), .AVERAGE(AVERAGE), .FRAME_DONE(FRAME_DONE), .LEVEL(LEVEL)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model state: edges since reset release, occupancy, samples in the current frame.
    int         edges = 0;
    int         lvl = 0;
    int         lvl_before = 0;
    int         fcnt = 0;
    bit         rst_prev = 1'b0;
    bit         hs_prev = 1'b0;
    bit         mode_prev = 1'b0;
    bit         exp_avg = 1'b0;
    bit         ex_en, ex_rs;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_data;

    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            check("rst_enable", ENABLE, 0);
            check("rst_restart", RESTART, 0);
            check("rst_done", FRAME_DONE, 0);
            check("rst_data", DATA_IN, 0);
            check("rst_level", LEVEL, 0);
            check("rst_ready", IN_READY, 1);
            rst_prev  = 1'b0;
            edges     = 0;
            lvl       = 0;
            fcnt      = 0;
            exp_avg   = 1'b0;
            last_data = 8'h00;
            hs_prev   = 1'b0;
        end else begin
            if (rst_prev) begin
                edges++;
                lvl_before = lvl;
                lvl += int'(hs_prev);
                if (edges <= 2) begin
                    ex_en = 1'b0;
                    ex_rs = 1'b0;
                    if (edges == 2) exp_avg = mode_prev;
                end else if (fcnt == FRAME_LEN) begin
                    ex_en   = 1'b0;
                    ex_rs   = 1'b1;
                    fcnt    = 0;
                    exp_avg = mode_prev;
                end else begin
                    ex_en = (lvl_before > 0);
                    ex_rs = 1'b0;
                end
                check("enable", ENABLE, ex_en);
                check("restart", RESTART, ex_rs);
                check("frame_done", FRAME_DONE, ex_rs);
                if (ex_en) begin
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 1, 0);
                    end else begin
                        exp_data = exp_q.pop_front();
                        check("data_out", DATA_IN, exp_data);
                        last_data = exp_data;
                    end
                    lvl--;
                    fcnt++;
                end else begin
                    check("data_hold", DATA_IN, last_data);
                end
                check("average", AVERAGE, exp_avg);
                check("level", LEVEL, lvl);
                check("in_ready", IN_READY, lvl != DEPTH);
            end else begin
                check("release_enable", ENABLE, 0);
                check("release_level", LEVEL, 0);
                check("release_ready", IN_READY, 1);
            end
            rst_prev  = 1'b1;
            hs_prev   = IN_VALID && IN_READY;
            mode_prev = MODE_AVG;
        end
    end

    // All driver tasks start and end #1 after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        for (int w = 0; w < 50; w++) begin
            @(negedge CLOCK);
            if (IN_READY) begin
                exp_q.push_back(d);
                @(posedge CLOCK);
                #1;
                IN_VALID = 1'b0;
                return;
            end
            @(posedge CLOCK);
            #1;
        end
        check("push_timeout", 1, 0);
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N  = 1'b0;
        IN_VALID = 1'b0;
        exp_q.delete();
        #1;
        check("async_enable", ENABLE, 0);
        check("async_restart", RESTART, 0);
        check("async_average", AVERAGE, 0);
        check("async_data", DATA_IN, 0);
        check("async_level", LEVEL, 0);
        check("async_ready", IN_READY, 1);
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        idle(6);

        push(8'h05);
        push(8'h80);
        push(8'h7F);
        idle(6);

        for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
        idle(6);

        MODE_AVG = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) MODE_AVG = 1'b0;
            push(8'(8'hA0 + i));
        end
        idle(12);

        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        idle(10);

        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 120 && !hit; i++) begin
                push(8'($urandom));
                if (LEVEL == 3 && edges > 2 && fcnt > 1 && fcnt < FRAME_LEN - 1) hit = 1'b1;
            end
            check("found_level3_midframe", hit, 1);
            @(negedge CLOCK);
            #1;
            do_reset();
        end
        idle(4);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 7) == 0) MODE_AVG = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) push(8'($urandom));
                else idle($urandom_range(1, 3));
            end
            idle(12);
            if (r == 1) do_reset();
        end
        idle(12);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
